// File: rtl/mpmc11_ch_arbiter.sv
// mpmc11_ch_arbiter
//   Round-robin arbiter between NCH requester channels of the mpmc11
//   controller. It picks one pending command per round and writes it into the
//   shared command FIFO. A channel can lock ownership across several commands
//   (read-modify-write, multi-beat sequences). The hold input stalls new grants
//   during refresh or calibration.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   req        per-channel request valid, held until ack
//   lock       per-channel lock, sampled when that channel is acked
//   cmd_i      per-channel command, channel i at [i*CMDW +: CMDW]
//   hold       block new grants from IDLE
//   fifo_full  command FIFO cannot take a write this cycle
//   fifo_wr    command FIFO write strobe
//   fifo_din   command FIFO write data
//   ack        one-hot, one-cycle pulse: command of that channel consumed
//   grant_v    a grant is registered (SEL or LOCKED)
//   grant_ch   currently or last granted channel
//   busy       arbiter is not idle
module mpmc11_ch_arbiter #(
  parameter  int NCH  = 8,
  parameter  int CMDW = 256,
  localparam int CHW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    lock,
  input  logic [NCH*CMDW-1:0] cmd_i,
  input  logic              hold,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [CMDW-1:0]   fifo_din,
  output logic [NCH-1:0]    ack,
  output logic              grant_v,
  output logic [CHW-1:0]    grant_ch,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEL    = 2'd1;
  localparam logic [1:0] PUSH   = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  logic [1:0]      state, state_n;
  logic [CHW-1:0]  last, last_n;
  logic [NCH-1:0]  ack_prev;

  logic [CHW-1:0]  grant_ch_n;
  logic            grant_v_n;
  logic            busy_n;
  logic            fifo_wr_n;
  logic [CMDW-1:0] fifo_din_n;
  logic [NCH-1:0]  ack_n;

  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  rot;
  logic [31:0]     base;
  logic            scan_hit;
  logic [CHW-1:0]  scan_ch;

  logic            own_req;
  logic            own_lock;
  logic            own_acked;
  logic [CMDW-1:0] own_cmd;

  // Round-robin scan: rotate the eligible vector so bit 0 is channel last+1,
  // take the lowest set bit, then map it back to an absolute channel index.
  always_comb begin
    eligible = req & ~ack_prev;
    base     = 32'(last) + 32'd1;
    if (base >= 32'(NCH)) begin
      base = '0;
    end
    rot      = NCH'({eligible, eligible} >> base);
    scan_hit = 1'b0;
    scan_ch  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!scan_hit && rot[i]) begin
        scan_hit = 1'b1;
        scan_ch  = CHW'((base + 32'(i)) % 32'(NCH));
      end
    end
  end

  always_comb begin
    own_req   = req[grant_ch];
    own_lock  = lock[grant_ch];
    own_acked = ack[grant_ch];
    own_cmd   = cmd_i[32'(grant_ch)*CMDW +: CMDW];
  end

  always_comb begin
    state_n    = state;
    last_n     = last;
    grant_ch_n = grant_ch;
    fifo_wr_n  = 1'b0;
    fifo_din_n = fifo_din;
    ack_n      = '0;

    case (state)
      IDLE: begin
        if (scan_hit && !hold) begin
          grant_ch_n = scan_ch;
          state_n    = SEL;
        end
      end
      SEL: begin
        if (!own_req) begin
          state_n = IDLE;
        end else if (!fifo_full) begin
          fifo_wr_n       = 1'b1;
          fifo_din_n      = own_cmd;
          ack_n[grant_ch] = 1'b1;
          last_n          = grant_ch;
          state_n         = own_lock ? LOCKED : PUSH;
        end
      end
      PUSH: begin
        state_n = IDLE;
      end
      LOCKED: begin
        // The requester only sees ack at the end of the ack cycle, so req is
        // still stale then; the next push waits until ack has dropped.
        if (own_req && !fifo_full && !own_acked) begin
          fifo_wr_n       = 1'b1;
          fifo_din_n      = own_cmd;
          ack_n[grant_ch] = 1'b1;
          last_n          = grant_ch;
          state_n         = own_lock ? LOCKED : PUSH;
        end else if (!own_req && !own_lock) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    grant_v_n = (state_n == SEL) || (state_n == LOCKED);
    busy_n    = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= CHW'(NCH - 1);
      ack_prev <= '0;
      grant_ch <= '0;
      grant_v  <= 1'b0;
      busy     <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      ack      <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      ack_prev <= ack;
      grant_ch <= grant_ch_n;
      grant_v  <= grant_v_n;
      busy     <= busy_n;
      fifo_wr  <= fifo_wr_n;
      fifo_din <= fifo_din_n;
      ack      <= ack_n;
    end
  end

endmodule

// File: tb/tb_mpmc11_ch_arbiter.sv
// Testbench for mpmc11_ch_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all outputs checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_mpmc11_ch_arbiter;

  localparam int NCH  = 8;
  localparam int CMDW = 256;
  localparam int CHW  = $clog2(NCH);

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      lock;
  logic [NCH*CMDW-1:0] cmd_i;
  logic                hold;
  logic                fifo_full;
  logic                fifo_wr;
  logic [CMDW-1:0]     fifo_din;
  logic [NCH-1:0]      ack;
  logic                grant_v;
  logic [CHW-1:0]      grant_ch;
  logic                busy;

  int total = 0;
  int bad   = 0;

  mpmc11_ch_arbiter #(.NCH(NCH), .CMDW(CMDW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .cmd_i(cmd_i),
    .hold(hold), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .ack(ack), .grant_v(grant_v),
    .grant_ch(grant_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CMDW-1:0] act,
                     input logic [CMDW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CMDW-1:0] rand_cmd();
    logic [CMDW-1:0] w;
    for (int i = 0; i < CMDW/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic set_cmd(input int c, input logic [CMDW-1:0] w);
    cmd_i[c*CMDW +: CMDW] = w;
  endtask

  // ---------------- behavioural model ----------------
  // Ownership view: a channel owns the arbiter from grant until release.
  // m_held   : owner keeps the arbiter after its ack (locked sequence)
  // m_pushed : owner's final command was written, release on next cycle
  int              m_own;
  bit              m_held, m_pushed;
  int              m_rr;
  int              m_ackp;
  logic            e_wr;
  logic [CMDW-1:0] e_din;
  int              e_ack;
  bit              e_gv, e_busy;
  int              e_gch;
  logic [NCH-1:0]  e_ackv;

  task automatic model_step();
    int cur_ack;
    bit do_push;
    int c;
    if (rst) begin
      m_own = -1; m_held = 0; m_pushed = 0; m_rr = NCH - 1; m_ackp = -1;
      e_wr = 0; e_din = '0; e_ack = -1; e_gv = 0; e_gch = 0; e_busy = 0;
      return;
    end
    cur_ack = e_ack;
    do_push = 0;
    e_wr    = 0;
    e_ack   = -1;
    if (m_own < 0) begin
      if (!hold) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (req[c] && c != m_ackp) begin
            m_own = c; e_gch = c;
            break;
          end
        end
      end
    end else if (m_pushed) begin
      m_own = -1; m_pushed = 0;
    end else if (!m_held) begin
      if (!req[m_own]) m_own = -1;
      else if (!fifo_full) begin
        do_push = 1;
        if (lock[m_own]) m_held = 1; else m_pushed = 1;
      end
    end else begin
      if (req[m_own] && !fifo_full && cur_ack != m_own) begin
        do_push = 1;
        if (!lock[m_own]) begin m_held = 0; m_pushed = 1; end
      end else if (!req[m_own] && !lock[m_own]) begin
        m_own = -1; m_held = 0;
      end
    end
    if (do_push) begin
      e_wr  = 1;
      e_din = cmd_i[m_own*CMDW +: CMDW];
      e_ack = m_own;
      m_rr  = m_own;
    end
    m_ackp = cur_ack;
    e_gv   = (m_own >= 0) && !m_pushed;
    e_busy = (m_own >= 0);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    e_ackv = '0;
    if (e_ack >= 0) e_ackv[e_ack] = 1'b1;
    chk("m_fifo_wr", fifo_wr, e_wr);
    chk("m_fifo_din", fifo_din, e_din);
    chk("m_ack", ack, e_ackv);
    chk("m_grant_v", grant_v, e_gv);
    chk("m_grant_ch", grant_ch, e_gch);
    chk("m_busy", busy, e_busy);
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1; req = '0; lock = '0; hold = 0; fifo_full = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req &= ~ack;
      if (req == '0 && !busy) break;
    end
    chk("drain_idle", busy, 0);
  endtask

  logic [CMDW-1:0] wa, wb;
  logic [NCH-1:0]  dropped;
  int              n, cyc, prev_t, ch, c1;
  int              lock_exp[4] = '{1, 1, 1, 3};
  int              beats[NCH];

  initial begin
    rst = 1; req = '0; lock = '0; cmd_i = '0; hold = 0; fifo_full = 0;
    foreach (beats[i]) beats[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_grant_v", grant_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_grant_ch", grant_ch, 0);
    rst = 0;

    // single request on ch2
    wa = rand_cmd(); set_cmd(2, wa); req = 8'h04;
    @(negedge clk);
    chk("single_gch", grant_ch, 2);
    chk("single_gv", grant_v, 1);
    chk("single_nowr", fifo_wr, 0);
    @(negedge clk);
    chk("single_wr", fifo_wr, 1);
    chk("single_din", fifo_din, wa);
    chk("single_ack", ack, 8'h04);
    req = '0;
    @(negedge clk);
    chk("single_busy", busy, 0);

    // round robin from a fresh pointer
    do_reset();
    for (int c = 0; c < NCH; c++) set_cmd(c, rand_cmd());
    req = '1; dropped = '0; n = 0; cyc = 0; prev_t = 0;
    while (n < 9 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (dropped != '0) begin req |= dropped; dropped = '0; end
      if (ack != '0) begin
        ch = -1;
        for (int i = 0; i < NCH; i++) if (ack[i]) ch = i;
        chk("rr_order", ch, n % NCH);
        if (n > 0) chk("rr_gap", cyc - prev_t, 3);
        prev_t = cyc; n++;
        req &= ~ack; dropped = ack;
      end
    end
    chk("rr_count", n, 9);
    req = '0;
    drain();

    // back-pressure on ch5 (pointer is at 0)
    wb = rand_cmd(); set_cmd(5, wb); req = 8'h20; fifo_full = 1;
    @(negedge clk);
    chk("bp_gch", grant_ch, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_nowr", fifo_wr, 0);
      chk("bp_gv", grant_v, 1);
      chk("bp_gch_hold", grant_ch, 5);
    end
    fifo_full = 0;
    @(negedge clk);
    chk("bp_wr", fifo_wr, 1);
    chk("bp_din", fifo_din, wb);
    chk("bp_ack", ack, 8'h20);
    req = '0;
    drain();

    // lock: ch1 three commands, ch3 waits (pointer at 5 → ch1 wins first)
    set_cmd(1, rand_cmd()); set_cmd(3, rand_cmd());
    req = 8'h0A; lock = 8'h02; n = 0; cyc = 0; c1 = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (ack != '0) begin
        ch = -1;
        for (int i = 0; i < NCH; i++) if (ack[i]) ch = i;
        chk("lock_order", ch, lock_exp[n]);
        n++;
        if (ch == 1) begin
          c1++;
          if (c1 < 3) begin set_cmd(1, rand_cmd()); lock[1] = (c1 < 2); end
          else begin req[1] = 0; lock[1] = 0; end
        end else begin
          req[ch] = 0;
        end
      end
    end
    chk("lock_count", n, 4);
    lock = '0;
    drain();

    // hold blocks grants (pointer at 3)
    hold = 1; req = 8'h01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_nogv", grant_v, 0);
    end
    hold = 0;
    @(negedge clk);
    chk("hold_gch", grant_ch, 0);
    chk("hold_gv", grant_v, 1);
    drain();

    // withdraw in SEL leaves pointer at 0
    req = 8'h10;
    @(negedge clk);
    chk("wd_gch", grant_ch, 4);
    req = '0;
    @(negedge clk);
    chk("wd_gv", grant_v, 0);
    chk("wd_nowr", fifo_wr, 0);
    chk("wd_busy", busy, 0);
    req = 8'h50;
    @(negedge clk);
    chk("wd_regrant", grant_ch, 4);
    drain();

    // reset while in SEL
    req = 8'h20; fifo_full = 1;
    @(negedge clk);
    chk("rs_gch", grant_ch, 5);
    rst = 1;
    @(negedge clk);
    chk("rs_gv", grant_v, 0);
    chk("rs_wr", fifo_wr, 0);
    chk("rs_ack", ack, 0);
    chk("rs_busy", busy, 0);
    chk("rs_gch0", grant_ch, 0);
    chk("rs_din", fifo_din, 0);
    rst = 0; req = 8'h81; fifo_full = 0;
    @(negedge clk);
    chk("rs_first", grant_ch, 0);
    drain();

    // randomized traffic
    req = '0; lock = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst       = ($urandom_range(499) == 0);
      hold      = ($urandom_range(7) == 0);
      fifo_full = ($urandom_range(3) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (ack[c]) begin
          if (beats[c] > 0) beats[c]--;
          if (beats[c] > 0) begin set_cmd(c, rand_cmd()); lock[c] = (beats[c] > 1); end
          else begin req[c] = 0; lock[c] = 0; end
        end else if (!req[c]) begin
          if ($urandom_range(3) == 0) begin
            beats[c] = $urandom_range(3, 1);
            req[c]   = 1;
            lock[c]  = (beats[c] > 1);
            set_cmd(c, rand_cmd());
          end
        end else if ($urandom_range(63) == 0) begin
          req[c] = 0; lock[c] = 0;
        end
      end
    end
    rst = 0; hold = 0; fifo_full = 0; req = '0; lock = '0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpmc11_ch_arbiter.md
Name: mpmc11_ch_arbiter

Overview:
- Round-robin arbiter between NCH requester channels (CPU, video, DMA, …) in the mpmc11 controller.
- Selects one pending command per arbitration round and pushes it into the shared command FIFO that feeds the mpmc11 sequencing state machine.
- Supports a per-channel lock so a read-modify-write or multi-beat sequence keeps exclusive ownership.
- Honours a hold input so the controller can stall new commands during refresh or calibration.

Parameters:
- NCH, 8, number of requester channels (2..16).
- CMDW, 256, width of one command word (fta_cmd_request256_t packed).
- CHW, $clog2(NCH), width of the channel index (derived; not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NCH  per-channel request valid; held until ack
- lock  in  NCH  per-channel lock; sampled at ack of that channel
- cmd_i  in  NCH*CMDW  per-channel command; channel i occupies bits [i*CMDW +: CMDW]
- hold  in  1  block new grants (refresh pending / calib incomplete)
- fifo_full  in  1  command FIFO cannot accept a write this cycle
- fifo_wr  out  1  command FIFO write strobe
- fifo_din  out  CMDW  command FIFO write data
- ack  out  NCH  one-hot, one-cycle pulse: command of channel i consumed
- grant_v  out  1  a grant is registered (SEL or LOCKED state)
- grant_ch  out  CHW  currently or last granted channel
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE; fifo_wr=0; fifo_din=0; ack=0; grant_v=0; grant_ch=0; busy=0; round-robin pointer last=NCH-1, so channel 0 has first priority after reset.
- All outputs are registered.
- States are IDLE, SEL, PUSH, LOCKED.
- IDLE:
  - Eligible = req & ~ack_prev. A channel acked in the previous cycle is masked for one cycle so a stale req is not regranted.
  - If eligible!=0 and !hold, choose the first set bit scanning last+1, last+2, … modulo NCH. Wrap-around: a scan from NCH-1 continues at 0.
  - Register grant_ch, set grant_v=1, go to SEL. Otherwise stay in IDLE.
- SEL:
  - If req[grant_ch]==0 (requester withdrew), clear grant_v, go to IDLE, no push; last is unchanged.
  - Else if !fifo_full: next cycle fifo_wr=1, fifo_din=cmd_i[grant_ch], ack[grant_ch]=1, last<=grant_ch.
    - If lock[grant_ch]=1, go to LOCKED. Otherwise go to PUSH.
  - Else (fifo_full) stay in SEL, grant held.
  - hold does not cancel a grant already in SEL.
- PUSH: one-cycle state in which fifo_wr and ack are deasserted; clear grant_v; go to IDLE.
  - Sustained throughput is one command per 3 cycles, single or multi-channel.
- LOCKED:
  - Only grant_ch is eligible; grant_v stays 1; hold is ignored.
  - On req[grant_ch] with !fifo_full and the channel not acked last cycle: push and ack as in SEL.
    - If lock was sampled 0 at this ack, go to PUSH; otherwise stay in LOCKED.
  - If req[grant_ch]=0 and lock[grant_ch]=0, clear grant_v, go to IDLE.
- fifo_wr is never asserted while fifo_full=1 was sampled in the deciding cycle.
- At most one ack bit is set at any time, and exactly one command is written per ack.
- Simultaneous events:
  - A new req arriving during SEL/PUSH/LOCKED waits for the next IDLE scan.
  - hold rising in the same cycle as an IDLE scan blocks that scan.
- Reset mid-operation: state returns to IDLE, any in-flight push is abandoned (no fifo_wr, no ack), and last returns to NCH-1.

Test Plan:
- Single request: req=8'h04, cmd_i ch2=A, fifo_full=0 → grant_ch=2 the cycle after req; fifo_wr=1 with fifo_din=A and ack=8'h04 one cycle later; busy returns to 0 after PUSH.
- Round robin: req=8'hFF held, each channel dropping req after its ack → ack order ch0,1,…,7,0; exactly one fifo_wr per 3 cycles; no channel acked twice before all others.
- Back-pressure: grant to ch5, fifo_full=1 for 10 cycles → no fifo_wr, grant_v=1 and grant_ch=5 stable; fifo_full=0 → single write of ch5 cmd, ack=8'h20.
- Lock: ch1 lock=1 issues 3 commands while ch3 requests → three ch1 pushes with no ch3 ack between; ch1 drops lock on the third ack → ch3 acked next.
- Hold/withdraw: hold=1 with req=8'h01 → no grant for 20 cycles; hold=0 → grant ch0. Separately, grant ch4, then drop req[4] during SEL → IDLE, no write, pointer unchanged (next winner among {4,6} is 4 once re-requested).
- Reset: assert rst in SEL with fifo_full=1 → next cycle all outputs 0; after release, req=8'h81 → ch0 granted first.
